// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: issues instruction-memory reads over valid/ready and strobes the fetched word into the IR.
module instr_fetch_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              flush,
    output logic              im_rd,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_ready,
    input  logic [31:0]       im_rdata,
    output logic [31:0]       im_dout,
    output logic              IRwr,
    output logic              busy,
    output logic              misalign,
    output logic              bus_err
);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t            state_q, state_d;
    logic              rd_q, rd_d, irwr_q, irwr_d, busy_q, busy_d;
    logic              mis_q, mis_d, berr_q, berr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       dout_q, dout_d;
    logic [7:0]        cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        irwr_d  = 1'b0;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
        if (state_q == IDLE) begin
            if (fetch_req && pc_in[1:0] == 2'b00) begin
                addr_d  = pc_in;
                rd_d    = 1'b1;
                cnt_d   = '0;
                state_d = REQ;
            end else if (fetch_req) begin
                mis_d = 1'b1;
            end
        end else if (im_ready) begin
            rd_d    = 1'b0;
            state_d = IDLE;
            if (state_q == REQ && !flush) begin
                dout_d = im_rdata;
                irwr_d = 1'b1;
            end
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            berr_d  = 1'b1;
            rd_d    = 1'b0;
            state_d = IDLE;
        end else begin
            // the request stays on the bus while draining; it cannot be withdrawn
            cnt_d   = cnt_q + 8'd1;
            state_d = (state_q == REQ && flush) ? DRAIN : state_q;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            irwr_q  <= 1'b0;
            busy_q  <= 1'b0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            irwr_q  <= irwr_d;
            busy_q  <= busy_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    assign im_rd    = rd_q;
    assign im_addr  = addr_q;
    assign im_dout  = dout_q;
    assign IRwr     = irwr_q;
    assign busy     = busy_q;
    assign misalign = mis_q;
    assign bus_err  = berr_q;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed and random stimulus checked against a transaction-level fetch model.
module tb_instr_fetch_ctrl;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst, fetch_req, flush, im_ready;
    logic [31:0] pc_in, im_rdata;
    logic        im_rd, IRwr, busy, misalign, bus_err;
    logic [31:0] im_addr, im_dout;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: one outstanding transaction, optionally doomed by a flush
    bit          m_out, m_drop, e_irwr, e_mis, e_berr;
    int          m_age;
    logic [31:0] m_addr, m_dout;

    instr_fetch_ctrl #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_in(pc_in), .flush(flush),
        .im_rd(im_rd), .im_addr(im_addr), .im_ready(im_ready), .im_rdata(im_rdata),
        .im_dout(im_dout), .IRwr(IRwr), .busy(busy), .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model();
        e_irwr = 0;
        e_mis  = 0;
        e_berr = 0;
        if (rst) begin
            m_out  = 0;
            m_drop = 0;
            m_age  = 0;
            m_addr = 0;
            m_dout = 0;
        end else if (!m_out) begin
            if (fetch_req && pc_in % 4 == 0) begin
                m_out  = 1;
                m_drop = 0;
                m_age  = 0;
                m_addr = pc_in;
            end else if (fetch_req) begin
                e_mis = 1;
            end
        end else if (im_ready) begin
            m_out = 0;
            if (!m_drop && !flush) begin
                e_irwr = 1;
                m_dout = im_rdata;
            end
        end else if (m_age == TIMEOUT - 1) begin
            m_out  = 0;
            e_berr = 1;
        end else begin
            m_age++;
            if (flush) m_drop = 1;
        end
    endtask

    task automatic step(input logic f, input logic [31:0] pc, input logic fl,
                        input logic rdy, input logic [31:0] dat, input logic r);
        @(negedge clk);
        fetch_req = f;
        pc_in     = pc;
        flush     = fl;
        im_ready  = rdy;
        im_rdata  = dat;
        rst       = r;
        @(posedge clk);
        model();
        #1;
        chk("im_rd", 32'(im_rd), 32'(m_out));
        chk("busy", 32'(busy), 32'(m_out));
        chk("im_addr", im_addr, m_addr);
        chk("im_dout", im_dout, m_dout);
        chk("IRwr", 32'(IRwr), 32'(e_irwr));
        chk("misalign", 32'(misalign), 32'(e_mis));
        chk("bus_err", 32'(bus_err), 32'(e_berr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("reset_busy", 32'(busy), 0);
        idle(1);
        // zero-wait fetch
        step(1, 32'h40, 0, 0, 0, 0);
        chk("zw_addr", im_addr, 32'h40);
        step(0, 0, 0, 1, 32'h13, 0);
        chk("zw_irwr", 32'(IRwr), 1);
        chk("zw_dout", im_dout, 32'h13);
        idle(1);
        // three wait states
        step(1, 32'h100, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("ws_addr", im_addr, 32'h100);
        step(0, 0, 0, 1, 32'h00A00093, 0);
        chk("ws_dout", im_dout, 32'h00A00093);
        idle(1);
        // flush while waiting, then drain
        step(1, 32'h200, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("dr_rd_held", 32'(im_rd), 1);
        step(0, 0, 0, 1, 32'hDEADBEEF, 0);
        chk("dr_dout_kept", im_dout, 32'h00A00093);
        idle(1);
        // flush coincident with ready
        step(1, 32'h300, 0, 0, 0, 0);
        step(0, 0, 1, 1, 32'hCAFEF00D, 0);
        chk("fc_irwr", 32'(IRwr), 0);
        // back-to-back: new fetch on the IRwr cycle
        step(1, 32'h400, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h11111111, 0);
        step(1, 32'h404, 0, 0, 0, 0);
        chk("b2b_rd", 32'(im_rd), 1);
        step(0, 0, 0, 1, 32'h22222222, 0);
        idle(1);
        // misaligned
        step(1, 32'h102, 0, 0, 0, 0);
        chk("mis_pulse", 32'(misalign), 1);
        idle(2);
        // timeout
        step(1, 32'h500, 0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT; i++) step(0, 0, 0, 0, 0, 0);
        chk("to_berr", 32'(bus_err), 1);
        idle(2);
        // reset mid-request, late ready ignored
        step(1, 32'h600, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 32'h33333333, 0);
        idle(1);
        // random traffic with varying memory responsiveness
        for (int b = 0; b < 40; b++) begin
            int rp;
            rp = (b % 4 == 3) ? 2 : $urandom_range(10, 80);
            for (int i = 0; i < 60; i++)
                step($urandom_range(0, 99) < 40,
                     ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
                     $urandom_range(0, 99) < 10,
                     $urandom_range(0, 99) < rp,
                     $urandom,
                     $urandom_range(0, 199) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
